// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Package : simon_pkg
// Tone and jingle encodings, tone frequencies, jingle tables and the
// half-period helper shared by simon_sound and tone_gen.
// Rev     : 1.0 - initial release
// ============================================================================
package simon_pkg;

   typedef enum logic [2:0] {T0, T1, T2, T3, TL, SIL} tone_e;
   typedef enum logic [1:0] {WIN, LOSE, HS} jingle_e;
   typedef enum logic [0:0] {IDLE, JINGLE} state_e;

   localparam int unsigned c_f_t0_hz = 415;
   localparam int unsigned c_f_t1_hz = 310;
   localparam int unsigned c_f_t2_hz = 252;
   localparam int unsigned c_f_t3_hz = 209;
   localparam int unsigned c_f_tl_hz = 42;

   function automatic int unsigned half_period(input int unsigned clk_hz,
                                               input int unsigned f_hz);
      int unsigned hp;
      hp = clk_hz / (2 * f_hz);
      return (hp == 0) ? 32'd1 : hp;
   endfunction

   // Larger value wins when triggers collide or arrive mid-jingle.
   function automatic logic [1:0] jingle_prio(input jingle_e j);
      logic [1:0] p;
      case (j)
         LOSE:    p = 2'd2;
         WIN:     p = 2'd1;
         default: p = 2'd0;
      endcase
      return p;
   endfunction

   function automatic logic [2:0] jingle_len(input jingle_e j);
      logic [2:0] n;
      case (j)
         WIN:     n = 3'd4;
         LOSE:    n = 3'd3;
         default: n = 3'd5;
      endcase
      return n;
   endfunction

   function automatic tone_e jingle_tone(input jingle_e j, input logic [2:0] slot);
      tone_e t;
      case (j)
         WIN:     t = (slot <= 3'd3) ? tone_e'(slot) : SIL;
         LOSE:    t = TL;
         HS:      t = slot[0] ? SIL : T0;
         default: t = SIL;
      endcase
      return t;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
// Module  : tone_gen
// Square-wave generator: half-period counter plus toggle register driven by
// a tone code. A tone change restarts the count without disturbing the level.
// Rev     : 1.0 - initial release
// ============================================================================
module tone_gen
   import simon_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
   input  logic  clk,
   input  logic  rst_n,
   input  tone_e tone_i,
   output logic  spk_o
);

   localparam int unsigned c_hp_t0 = half_period(CLK_FREQ_HZ, c_f_t0_hz);
   localparam int unsigned c_hp_t1 = half_period(CLK_FREQ_HZ, c_f_t1_hz);
   localparam int unsigned c_hp_t2 = half_period(CLK_FREQ_HZ, c_f_t2_hz);
   localparam int unsigned c_hp_t3 = half_period(CLK_FREQ_HZ, c_f_t3_hz);
   localparam int unsigned c_hp_tl = half_period(CLK_FREQ_HZ, c_f_tl_hz);
   // TL is the lowest pitch, so its half-period bounds the counter.
   localparam int unsigned c_cw    = (c_hp_tl > 1) ? $clog2(c_hp_tl) : 1;

   tone_e            tone_q;
   logic [c_cw-1:0]  cnt_q;
   logic             spk_q;
   logic [c_cw-1:0]  hp_m1;

   always_comb begin
      case (tone_q)
         T0:      hp_m1 = c_cw'(c_hp_t0 - 1);
         T1:      hp_m1 = c_cw'(c_hp_t1 - 1);
         T2:      hp_m1 = c_cw'(c_hp_t2 - 1);
         T3:      hp_m1 = c_cw'(c_hp_t3 - 1);
         TL:      hp_m1 = c_cw'(c_hp_tl - 1);
         default: hp_m1 = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tone_q <= SIL;
         cnt_q  <= '0;
         spk_q  <= 1'b0;
      end else if (tone_i != tone_q) begin
         tone_q <= tone_i;
         cnt_q  <= '0;
         if (tone_i == SIL) begin
            spk_q <= 1'b0;
         end
      end else if (tone_q == SIL) begin
         cnt_q <= '0;
         spk_q <= 1'b0;
      end else if (cnt_q == hp_m1) begin
         cnt_q <= '0;
         spk_q <= ~spk_q;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign spk_o = spk_q;

endmodule
`default_nettype wire

// File: rtl/simon_sound.sv
`default_nettype none
// ============================================================================
// Module  : simon_sound
// Simon audio back end: lamp tones, plus win/lose/high-score jingles when
// built with SIMON_SOUND_JINGLE_EN defined (lamp tones only otherwise).
// Rev     : 1.0 - initial release
// ============================================================================
module simon_sound
   import simon_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned NOTE_CYCLES = 12_500_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] butt_out,
   input  logic       butt_ena,
   input  logic       win,
   input  logic       lose,
   input  logic       hs,
   output logic       spk,
   output logic       busy
);

   tone_e lamp_tone;
   tone_e tone_d;

   always_comb begin
      lamp_tone = butt_ena ? tone_e'({1'b0, butt_out}) : SIL;
   end

`ifdef SIMON_SOUND_JINGLE_EN
   localparam int unsigned c_scw = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;

   // Flag vectors are ordered {lose, win, hs}.
   logic [2:0]       lvl_q;
   logic [2:0]       prev_q;
   state_e           state_q, state_d;
   jingle_e          jingle_q, jingle_d;
   logic [2:0]       slot_q, slot_d;
   logic [c_scw-1:0] scnt_q, scnt_d;
   logic             busy_q;
   logic [2:0]       trig;
   logic             trig_any;
   jingle_e          trig_j;

   always_comb begin
      trig     = lvl_q & ~prev_q;
      trig_any = |trig;
      trig_j   = trig[2] ? LOSE : (trig[1] ? WIN : HS);
      state_d  = state_q;
      jingle_d = jingle_q;
      slot_d   = slot_q;
      scnt_d   = scnt_q;
      if (state_q == IDLE) begin
         if (trig_any) begin
            state_d  = JINGLE;
            jingle_d = trig_j;
            slot_d   = '0;
            scnt_d   = '0;
         end
      end else if (trig_any && (jingle_prio(trig_j) > jingle_prio(jingle_q))) begin
         jingle_d = trig_j;
         slot_d   = '0;
         scnt_d   = '0;
      end else if (scnt_q == c_scw'(NOTE_CYCLES - 1)) begin
         scnt_d = '0;
         if (slot_q == (jingle_len(jingle_q) - 3'd1)) begin
            state_d = IDLE;
            slot_d  = '0;
         end else begin
            slot_d = slot_q + 3'd1;
         end
      end else begin
         scnt_d = scnt_q + 1'b1;
      end
      // Selecting from next-state lets a new slot's tone start on its first edge.
      tone_d = (state_d == JINGLE) ? jingle_tone(jingle_d, slot_d) : lamp_tone;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_q    <= '0;
         prev_q   <= '0;
         state_q  <= IDLE;
         jingle_q <= WIN;
         slot_q   <= '0;
         scnt_q   <= '0;
         busy_q   <= 1'b0;
      end else begin
         lvl_q    <= {lose, win, hs};
         prev_q   <= lvl_q;
         state_q  <= state_d;
         jingle_q <= jingle_d;
         slot_q   <= slot_d;
         scnt_q   <= scnt_d;
         busy_q   <= (state_d == JINGLE);
      end
   end

   assign busy = busy_q;
`else
   logic unused_w;

   assign tone_d   = lamp_tone;
   assign busy     = 1'b0;
   assign unused_w = ^{win, lose, hs, NOTE_CYCLES[0]};
`endif

   tone_gen #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ)
   ) u_tone_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .tone_i (tone_d),
      .spk_o  (spk)
   );

endmodule
`default_nettype wire
